// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's three channels: imem request/response, execute redirect, decode output.
// The master modport is the fetch unit's view; the slave modport is the environment's view.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order fetch queue, redirect flush with in-flight response dropping.
// Optional macro FETCH_PERF_EN adds a saturating 32-bit fetch_count output of decode handshakes.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  fetch_count
`endif
);
  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  ent_pc_q   [DEPTH];
  logic [XLEN-1:0]  ent_data_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [PW-1:0]    alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
  logic [CW-1:0]    count_q, count_d, pend_q, pend_d, drop_q, drop_d;
  logic [CW:0]      used_s;
  logic             inst_valid_s, pop_s, req_valid_s, accept_s, rsp_fill_s, rsp_drop_s;
  logic [1:0]       redirect_lsb_unused_s;

  assign redirect_lsb_unused_s = bus.redirect_pc[1:0];

  // Handshake qualifiers; credits are queue entries plus responses still owed to a flushed stream.
  always_comb begin
    inst_valid_s = (count_q != {CW{1'b0}}) && filled_q[head_q];
    pop_s        = inst_valid_s && bus.inst_ready;
    used_s       = {1'b0, count_q} + {1'b0, drop_q} - {{CW{1'b0}}, pop_s};
    req_valid_s  = (used_s < DEPTH_W) && !bus.redirect_valid && !reset;
    accept_s     = req_valid_s && bus.imem_req_ready;
    rsp_fill_s   = bus.imem_rsp_valid && (drop_q == {CW{1'b0}});
    rsp_drop_s   = bus.imem_rsp_valid && (drop_q != {CW{1'b0}});
  end

  // Next-state for PC, pointers, occupancy and drop accounting.
  always_comb begin
    pc_d     = pc_q;
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    head_d   = head_q;
    filled_d = filled_q;
    count_d  = count_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    if (bus.redirect_valid) begin
      // Words still owed after this cycle's response become drops.
      pc_d     = {bus.redirect_pc[XLEN-1:2], 2'b00};
      alloc_d  = {PW{1'b0}};
      fill_d   = {PW{1'b0}};
      head_d   = {PW{1'b0}};
      filled_d = {DEPTH{1'b0}};
      count_d  = {CW{1'b0}};
      pend_d   = {CW{1'b0}};
      drop_d   = drop_q - CW'(rsp_drop_s) + pend_q - CW'(rsp_fill_s);
    end else begin
      count_d = count_q + CW'(accept_s) - CW'(pop_s);
      pend_d  = pend_q + CW'(accept_s) - CW'(rsp_fill_s);
      drop_d  = drop_q - CW'(rsp_drop_s);
      if (accept_s) begin
        pc_d    = pc_q + XLEN'(32'd4);
        alloc_d = alloc_q + PW'(1'b1);
      end else begin
        pc_d    = pc_q;
        alloc_d = alloc_q;
      end
      if (rsp_fill_s) begin
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PW'(1'b1);
      end else begin
        fill_d = fill_q;
      end
      if (pop_s) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1'b1);
      end else begin
        head_d = head_q;
      end
    end
  end

  // State registers and queue storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      alloc_q  <= {PW{1'b0}};
      fill_q   <= {PW{1'b0}};
      head_q   <= {PW{1'b0}};
      filled_q <= {DEPTH{1'b0}};
      count_q  <= {CW{1'b0}};
      pend_q   <= {CW{1'b0}};
      drop_q   <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]   <= {XLEN{1'b0}};
        ent_data_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      pc_q     <= pc_d;
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
      filled_q <= filled_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      if (accept_s) begin
        ent_pc_q[alloc_q] <= pc_q;
      end
      if (rsp_fill_s) begin
        ent_data_q[fill_q] <= bus.imem_rsp_data;
      end
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = inst_valid_s;
  assign bus.inst_data      = inst_valid_s ? ent_data_q[head_q] : {XLEN{1'b0}};
  assign bus.inst_pc        = inst_valid_s ? ent_pc_q[head_q]   : {XLEN{1'b0}};

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q;

  // Saturating count of decode handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
    end else if (pop_s && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end else begin
      fetch_count_q <= fetch_count_q;
    end
  end

  assign fetch_count = fetch_count_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected (pc, data) pairs, a monitor pops them.
module tb_fetch_unit;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MEM_KEY  = 32'hA5A5_5A5A;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_unit_if #(.XLEN(XLEN)) bus ();
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
`endif

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks  = 0;
  int          passes  = 0;
  int          cyc     = 0;
  int          lat     = 1;
  int          pop_cnt = 0;
  logic [31:0] exp_pc_q   [$];
  logic [31:0] exp_data_q [$];
  logic [31:0] mq_addr    [$];
  int          mq_due     [$];
  logic [31:0] req_log    [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_pc_q.push_back(pc);
    exp_data_q.push_back(pc ^ MEM_KEY);
  endtask

  function automatic logic [31:0] get_log(input int i);
    if (i < req_log.size()) return req_log[i];
    else return 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ir);
    reset              = 1'b1;
    bus.inst_ready     = ir;
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    req_log.delete();
    reset = 1'b0;
  endtask

  // Let decode consume until the pop counter reaches target, then stall decode again.
  task automatic drain_until(input int target, input int budget, output int used);
    used           = 0;
    bus.inst_ready = 1'b1;
    while (pop_cnt < target && used < budget) begin
      tick();
      used++;
    end
    bus.inst_ready = 1'b0;
    check("drain_pops", pop_cnt, target);
    check("exp_left", exp_pc_q.size(), 0);
  endtask

  // Instruction memory: in-order responses lat cycles after acceptance, word = addr ^ MEM_KEY.
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mq_addr.delete();
        mq_due.delete();
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        mq_addr.push_back(bus.imem_req_addr);
        mq_due.push_back(cyc + lat);
        req_log.push_back(bus.imem_req_addr);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        mq_addr.delete();
        mq_due.delete();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
      end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mq_addr.pop_front() ^ MEM_KEY;
        void'(mq_due.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
      end
    end
  end

  // Monitor: every decode handshake is compared against the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.inst_valid && bus.inst_ready) begin
        pop_cnt++;
        if (exp_pc_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_inst: got pc 0x%08h data 0x%08h, expected none", bus.inst_pc, bus.inst_data);
        end else begin
          check("inst_pc", bus.inst_pc, exp_pc_q.pop_front());
          check("inst_data", bus.inst_data, exp_data_q.pop_front());
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int used;
    int base;
    int k;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    tick();
    tick();
    check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_inst_data", bus.inst_data, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);
`ifdef FETCH_PERF_EN
    check("rst_fetch_count", fetch_count, 32'd0);
`endif

    // Streaming: 8 instructions, first pop two cycles after release, then one per cycle.
    lat = 1;
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) push_exp(32'h0 + 32'(4 * i));
    #2;
    check("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check("first_req_addr", bus.imem_req_addr, RESET_PC);
    drain_until(pop_cnt + 8, 30, used);
    check("stream_cycles", 32'(used), 32'd10);

    // Decode stalled: exactly DEPTH requests, then the request channel goes idle.
    do_reset(1'b0);
    repeat (10) tick();
    check("stall_req_count", req_log.size(), 2);
    check("stall_req0", get_log(0), 32'h0);
    check("stall_req1", get_log(1), 32'h4);
    @(negedge clk);
    check("stall_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("stall_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
    tick();
    push_exp(32'h0);
    push_exp(32'h4);
    drain_until(pop_cnt + 2, 20, used);
    check("resume_addr", get_log(2), 32'h8);

    // Redirect with two requests outstanding on a slow memory; late words must be dropped.
    lat = 3;
    do_reset(1'b1);
    tick();
    tick();
    check("outstanding", req_log.size(), 2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    #2;
    check("redir_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    k = req_log.size();
    push_exp(32'h100);
    push_exp(32'h104);
    drain_until(pop_cnt + 2, 40, used);
    check("redir_target", get_log(k), 32'h100);

    // Redirect coinciding with a response and a decode handshake.
    lat = 1;
    do_reset(1'b1);
    base = pop_cnt;
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    push_exp(32'h200);
    push_exp(32'h204);
    repeat (4) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    check("redir_hs_valid", {31'd0, bus.inst_valid}, 32'd1);
    check("redir_hs_pc", bus.inst_pc, 32'h8);
    check("redir_hs_req", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    k = req_log.size();
    drain_until(base + 5, 20, used);
    check("redir_next_addr", get_log(k), 32'h200);
`ifdef FETCH_PERF_EN
    check("fetch_count", fetch_count, 32'd5);
`endif

    // Asynchronous reset mid-flight with an instruction presented.
    repeat (3) tick();
    @(negedge clk);
    check("pre_rst_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("async_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("async_inst_data", bus.inst_data, 32'd0);
    check("async_inst_pc", bus.inst_pc, 32'd0);
    do_reset(1'b1);
    push_exp(32'h0);
    push_exp(32'h4);
    #2;
    check("restart_addr", bus.imem_req_addr, RESET_PC);
    drain_until(pop_cnt + 2, 20, used);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
